// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the mini-MIPS data memory: clear-sweep state enum,
// default geometry and a byte-lane merge used by the write and forwarding paths.
package mips_mem_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 1024;
  // Widest word byte_merge handles; callers zero-extend and truncate around it.
  localparam int MAX_DATA_W     = 256;
  localparam int MAX_BE_W       = MAX_DATA_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_t;

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    for (int i = 0; i < MAX_BE_W; i++) begin
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_clear_ctrl.sv
// Post-reset clear sweep controller: walks clr_cnt over every word, then parks in READY.
// o_state exposes the FSM state for debug and checker binding.
module mem_clear_ctrl
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          o_busy,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_addr,
  output mem_state_t    o_state
);

  mem_state_t    r_state;
  mem_state_t    w_next_state;
  logic [AW-1:0] r_clr_cnt;
  logic [AW-1:0] w_next_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_clr_cnt <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_clr_cnt;
    o_busy       = 1'b0;
    o_clr_we     = 1'b0;
    unique case (r_state)
      CLEAR: begin
        o_busy   = 1'b1;
        o_clr_we = 1'b1;
        if (r_clr_cnt == AW'(DEPTH - 1)) begin
          w_next_state = READY;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_clr_cnt + AW'(1);
        end
      end
      READY: begin
        w_next_state = READY;
      end
    endcase
  end

  assign o_clr_addr = r_clr_cnt;
  assign o_state    = r_state;

endmodule

// File: rtl/data_memory_v2.sv
// MEM-stage word memory with byte enables, optional registered read, clear sweep and
// out-of-range detection. Define DATA_MEMORY_V2_FWD_EN for same-address write forwarding.
module data_memory_v2
  import mips_mem_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int READ_LAT = 0,
  parameter int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_enable,
  input  logic [BE_W-1:0]   byte_en,
  input  logic [31:0]       write_address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enable,
  input  logic [31:0]       read_address,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_addr_err;

  logic              w_clr_we;
  logic [AW-1:0]     w_clr_addr;
  mem_state_t        w_state;
  logic              w_ready;
  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic [AW-1:0]     w_wr_idx;
  logic [AW-1:0]     w_rd_idx;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W-1:0] w_wr_old;
  logic [DATA_W-1:0] w_wr_merged;
  logic [DATA_W-1:0] w_rd_word;

  mem_clear_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .o_busy     (busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_state    (w_state)
  );

  // Range check uses the full 32-bit address; only then are the low bits trusted as an index.
  assign w_ready       = (w_state == READY);
  assign w_wr_in_range = (write_address < DEPTH_W);
  assign w_rd_in_range = (read_address < DEPTH_W);
  assign w_wr_idx      = write_address[AW-1:0];
  assign w_rd_idx      = read_address[AW-1:0];
  assign w_wr_acc      = w_ready & write_enable & w_wr_in_range;
  assign w_rd_acc      = w_ready & read_enable;

  assign w_wr_old    = r_mem[w_wr_idx];
  assign w_wr_merged = DATA_W'(byte_merge(MAX_DATA_W'(w_wr_old), MAX_DATA_W'(data_in),
                                          MAX_BE_W'(byte_en)));

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_acc) begin
      r_mem[w_wr_idx] <= w_wr_merged;
    end
  end

  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) begin
      w_rd_word = r_mem[w_rd_idx];
    end
`ifdef DATA_MEMORY_V2_FWD_EN
    if (w_rd_in_range && w_wr_acc && (read_address == write_address)) begin
      w_rd_word = w_wr_merged;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_ready & ((write_enable & ~w_wr_in_range) |
                               (read_enable & ~w_rd_in_range));
    end
  end

  assign addr_err = r_addr_err;

  if (READ_LAT == 0) begin : g_comb_read
    assign data_out = w_ready ? w_rd_word : '0;
    assign rd_valid = w_rd_acc;
  end else begin : g_reg_read
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;

    // data_out holds its last value between requests; only rd_valid drops.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_data_out <= '0;
        r_rd_valid <= 1'b0;
      end else if (w_rd_acc) begin
        r_data_out <= w_rd_word;
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end
    end

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
  end

endmodule

// File: tb/tb_data_memory_v2.sv
// Bench for data_memory_v2: combinational and registered-read instances share stimulus
// and are checked every cycle against a word-array reference model.
module tb_data_memory_v2;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_enable;
  logic [3:0]  byte_en;
  logic [31:0] write_address;
  logic [31:0] data_in;
  logic        read_enable;
  logic [31:0] read_address;

  logic [31:0] d0_data, d1_data;
  logic        d0_valid, d1_valid, d0_busy, d1_busy, d0_err, d1_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  int          m_busy_left;
  logic        m_lat1_valid;
  logic [31:0] m_lat1_data;
  logic        m_err;
  logic [31:0] exp_q [$];

  logic [31:0] last_d0_data;
  logic [31:0] last_d1_data;
  logic        last_d1_valid;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] wa;
    logic [31:0] din;
    logic        re;
    logic [31:0] ra;
    logic        chk0;
    logic [31:0] exp0;
    logic        chk1;
    logic        exp1_valid;
    logic [31:0] exp1_data;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  data_memory_v2 #(.DATA_W(32), .DEPTH(DEPTH), .READ_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .byte_en(byte_en),
    .write_address(write_address), .data_in(data_in), .read_enable(read_enable),
    .read_address(read_address), .data_out(d0_data), .rd_valid(d0_valid),
    .busy(d0_busy), .addr_err(d0_err)
  );

  data_memory_v2 #(.DATA_W(32), .DEPTH(DEPTH), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .write_enable(write_enable), .byte_en(byte_en),
    .write_address(write_address), .data_in(data_in), .read_enable(read_enable),
    .read_address(read_address), .data_out(d1_data), .rd_valid(d1_valid),
    .busy(d1_busy), .addr_err(d1_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
    logic [31:0] mask;
    mask = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mask = mask | (32'hFF << (8 * i));
    end
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  function automatic logic [31:0] model_read();
    if (read_address >= DEPTH) return 32'h0;
`ifdef DATA_MEMORY_V2_FWD_EN
    if (write_enable && (write_address == read_address) && (m_busy_left == 0))
      return m_merge(m_mem[read_address], data_in, byte_en);
`endif
    return m_mem[read_address];
  endfunction

  task automatic set_in(input logic we, input logic [3:0] be, input logic [31:0] wa,
                        input logic [31:0] din, input logic re, input logic [31:0] ra);
    write_enable  = we;
    byte_en       = be;
    write_address = wa;
    data_in       = din;
    read_enable   = re;
    read_address  = ra;
  endtask

  task automatic model_reset();
    m_busy_left  = DEPTH;
    m_lat1_valid = 1'b0;
    m_lat1_data  = 32'h0;
    m_err        = 1'b0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
  endtask

  // One clock: check all outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic [31:0] rd_v;
    logic        ready;
    @(negedge clk);
    ready = (m_busy_left == 0);
    rd_v  = model_read();
    if (m_lat1_valid && exp_q.size() > 0) m_lat1_data = exp_q.pop_front();
    check("busy0", 32'(d0_busy), 32'(!ready));
    check("busy1", 32'(d1_busy), 32'(!ready));
    check("rd_valid0", 32'(d0_valid), 32'(ready && read_enable));
    check("data_out0", d0_data, ready ? rd_v : 32'h0);
    check("rd_valid1", 32'(d1_valid), 32'(m_lat1_valid));
    check("data_out1", d1_data, m_lat1_data);
    check("addr_err0", 32'(d0_err), 32'(m_err));
    check("addr_err1", 32'(d1_err), 32'(m_err));
    last_d0_data  = d0_data;
    last_d1_data  = d1_data;
    last_d1_valid = d1_valid;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (ready) begin
      m_err        = (write_enable && write_address >= DEPTH) ||
                     (read_enable && read_address >= DEPTH);
      m_lat1_valid = read_enable;
      if (read_enable) exp_q.push_back(rd_v);
      if (write_enable && write_address < DEPTH)
        m_mem[write_address] = m_merge(m_mem[write_address], data_in, byte_en);
    end else begin
      m_err        = 1'b0;
      m_lat1_valid = 1'b0;
      m_busy_left--;
    end
    #1;
  endtask

  task automatic run_until_ready(input string name);
    int n;
    n = 0;
    while (n < 100) begin
      set_in(1'b1, 4'hF, 32'd1, $urandom, 1'b1, 32'd1);
      step();
      n++;
      if (!d0_busy) break;
    end
    check(name, 32'(n), 32'(DEPTH));
    set_in(1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'hF, 32'd5, 32'hAABBCCDD, 1'b0, 32'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 4'h5, 32'd5, 32'h11223344, 1'b0, 32'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 4'h0, 32'd0, 32'h0, 1'b1, 32'd5, 1'b1, 32'hAA22CC44, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 4'h0, 32'd0, 32'h0, 1'b0, 32'd0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hAA22CC44};
    vecs[4]  = '{1'b0, 4'h0, 32'd0, 32'h0, 1'b0, 32'd0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hAA22CC44};
    vecs[5]  = '{1'b1, 4'hF, 32'd16, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 4'h0, 32'd0, 32'h0, 1'b1, 32'd0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 4'h0, 32'd0, 32'h0, 1'b1, 32'd40, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 4'hF, 32'h10000007, 32'h12345678, 1'b1, 32'd7, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 4'hF, 32'd3, 32'h1, 1'b0, 32'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};
`ifdef DATA_MEMORY_V2_FWD_EN
    vecs[10] = '{1'b1, 4'hF, 32'd3, 32'h5, 1'b1, 32'd3, 1'b1, 32'h5, 1'b0, 1'b0, 32'h0};
`else
    vecs[10] = '{1'b1, 4'hF, 32'd3, 32'h5, 1'b1, 32'd3, 1'b1, 32'h1, 1'b0, 1'b0, 32'h0};
`endif
    vecs[11] = '{1'b0, 4'h0, 32'd0, 32'h0, 1'b1, 32'd3, 1'b1, 32'h5, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 4'h8, 32'd9, 32'hCAFEF00D, 1'b1, 32'd5, 1'b1, 32'hAA22CC44, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 4'h0, 32'd0, 32'h0, 1'b1, 32'd9, 1'b1, 32'hCA000000, 1'b0, 1'b0, 32'h0};

    // Clock/reset: hold reset two cycles, then check the reset state with reset still low.
    rst_n = 1'b0;
    set_in(1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    step();

    // Clear sweep with writes attempted while busy; all words must then read 0.
    rst_n = 1'b1;
    run_until_ready("sweep_cycles");
    for (int a = 0; a < DEPTH; a++) begin
      set_in(1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 32'(a));
      step();
      check($sformatf("clear_addr%0d", a), last_d0_data, 32'h0);
    end

    // Directed table
    for (int i = 0; i < 14; i++) begin
      set_in(vecs[i].we, vecs[i].be, vecs[i].wa, vecs[i].din, vecs[i].re, vecs[i].ra);
      step();
      if (vecs[i].chk0) check($sformatf("vec%0d_rd", i), last_d0_data, vecs[i].exp0);
      if (vecs[i].chk1) begin
        check($sformatf("vec%0d_lat1_valid", i), 32'(last_d1_valid), 32'(vecs[i].exp1_valid));
        check($sformatf("vec%0d_lat1_data", i), last_d1_data, vecs[i].exp1_data);
      end
    end

    // Reset in READY, then again mid-sweep: sweep restarts and wipes addr 2.
    set_in(1'b1, 4'hF, 32'd2, 32'h7, 1'b0, 32'd0);
    step();
    set_in(1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 32'd2);
    step();
    check("pre_reset_addr2", last_d0_data, 32'h7);
    rst_n = 1'b0;
    set_in(1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run_until_ready("resweep_cycles");
    set_in(1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 32'd2);
    step();
    check("post_reset_addr2", last_d0_data, 32'h0);

    // Randomized traffic with frequent address collisions and out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] wa, ra;
      wa = 32'($urandom_range(0, 19));
      ra = 32'($urandom_range(0, 19));
      if ($urandom_range(0, 7) == 0) wa = wa | 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) ra = wa;
      set_in(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), wa, $urandom,
             1'($urandom_range(0, 1)), ra);
      step();
    end
    set_in(1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 32'd0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
